// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch (I) and load/store (D) ports.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int WORDS        = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          grant_i, grant_d;
  logic          i_legal, d_legal;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(WORDS));
  endfunction

  assign i_legal = addr_legal(i_req_addr);
  assign d_legal = addr_legal(d_req_addr);
  assign starved = (starve_cnt >= SW'(STARVE_LIMIT));

  // Data port wins conflicts unless fetch has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (d_req_valid && !(i_req_valid && starved)) grant_d = 1'b1;
      else if (i_req_valid)                          grant_i = 1'b1;
    end
  end

  assign i_req_ready      = grant_i;
  assign d_req_ready      = grant_d;
  assign mem_address      = grant_d ? d_req_addr : (grant_i ? i_req_addr : 32'h0);
  assign mem_write_data   = d_req_wdata;
  assign mem_write_enable = grant_d && d_req_we && d_legal;

  // Read data is sampled at the grant edge, so a store landing on that edge is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else begin
      i_rsp_valid <= grant_i;
      i_rsp_err   <= grant_i && !i_legal;
      i_rsp_data  <= (grant_i && i_legal) ? mem_read_data : '0;
      d_rsp_valid <= grant_d;
      d_rsp_err   <= grant_d && !d_legal;
      d_rsp_data  <= (grant_d && d_legal && !d_req_we) ? mem_read_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           starve_cnt <= '0;
    else if (!i_req_valid || grant_i)  starve_cnt <= '0;
    else if (grant_d && !starved)      starve_cnt <= starve_cnt + SW'(1);
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_i)                    perf_i_grants  <= perf_i_grants + 32'd1;
      if (grant_d)                    perf_d_grants  <= perf_d_grants + 32'd1;
      if (i_req_valid && d_req_valid) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int WORDS = 64;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic        d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
  logic [31:0] pc0;
`endif

  mem_port_arbiter #(.WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(WORDS));
  endfunction

  // Memory instance stand-in: combinational read, write on the rising edge.
  logic [31:0] mem [WORDS];
  assign mem_read_data = legal({mem_address[31:2], 2'b00}) ? mem[mem_address[7:2]] : 32'h0;
  initial begin
    for (int k = 0; k < WORDS; k++) mem[k] = 32'h1000_0000 + 32'(k);
    mem[2] = 32'hDEADBEEF;
    forever @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
  end

  // Reference model: arbitration by loss count, expected responses one cycle later.
  logic [31:0] ref_mem [WORDS];
  logic        e_iv, e_ie, e_dv, e_de, m_gi, m_gd, il, dl;
  logic [31:0] e_id, e_dd;
  int          losses;
  initial begin
    for (int k = 0; k < WORDS; k++) ref_mem[k] = 32'h1000_0000 + 32'(k);
    ref_mem[2] = 32'hDEADBEEF;
    e_iv = 0; e_ie = 0; e_dv = 0; e_de = 0; e_id = 0; e_dd = 0; losses = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        chk("rst_i_rsp", {i_rsp_valid, i_rsp_err}, 0);
        chk("rst_d_rsp", {d_rsp_valid, d_rsp_err}, 0);
        chk("rst_i_data", i_rsp_data, 0);
        chk("rst_d_data", d_rsp_data, 0);
        e_iv = 0; e_dv = 0; losses = 0;
      end else begin
        il = legal(i_req_addr);
        dl = legal(d_req_addr);
        m_gi = i_req_valid && (!d_req_valid || losses >= LIMIT);
        m_gd = d_req_valid && !m_gi;
        chk("i_ready", i_req_ready, m_gi);
        chk("d_ready", d_req_ready, m_gd);
        chk("mem_addr", mem_address, m_gd ? d_req_addr : (m_gi ? i_req_addr : 32'h0));
        chk("mem_we", mem_write_enable, m_gd && d_req_we && dl);
        if (m_gd && d_req_we && dl) chk("mem_wdata", mem_write_data, d_req_wdata);
        chk("i_rsp_valid", i_rsp_valid, e_iv);
        if (e_iv) begin
          chk("i_rsp_data", i_rsp_data, e_id);
          chk("i_rsp_err", i_rsp_err, e_ie);
        end
        chk("d_rsp_valid", d_rsp_valid, e_dv);
        if (e_dv) begin
          chk("d_rsp_data", d_rsp_data, e_dd);
          chk("d_rsp_err", d_rsp_err, e_de);
        end
        e_iv = m_gi;
        e_ie = m_gi && !il;
        e_id = (m_gi && il) ? ref_mem[i_req_addr[7:2]] : 32'h0;
        e_dv = m_gd;
        e_de = m_gd && !dl;
        e_dd = (m_gd && dl && !d_req_we) ? ref_mem[d_req_addr[7:2]] : 32'h0;
        if (m_gd && dl && d_req_we) ref_mem[d_req_addr[7:2]] = d_req_wdata;
        if (!i_req_valid || m_gi) losses = 0;
        else if (losses < LIMIT)  losses = losses + 1;
      end
    end
  end

  // Snapshot of DUT outputs taken mid-cycle for the directed checks.
  logic        s_ir, s_dr, s_we, s_iv, s_ie, s_dv, s_de;
  logic [31:0] s_id, s_dd;

  task automatic cyc();
    @(negedge clk);
    s_ir = i_req_ready; s_dr = d_req_ready; s_we = mem_write_enable;
    s_iv = i_rsp_valid; s_id = i_rsp_data;  s_ie = i_rsp_err;
    s_dv = d_rsp_valid; s_dd = d_rsp_data;  s_de = d_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    s_ir = 1'b0; s_dr = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(64, 80)) << 2;
    if (r == 1) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  string pat;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("post_rst_i_vld", s_iv, 0);
    chk("post_rst_d_vld", s_dv, 0);

    // Fetch of preloaded word 2.
    i_req_valid = 1; i_req_addr = 32'h8;
    cyc(); chk("fetch_ready", s_ir, 1);
    i_req_valid = 0;
    cyc(); chk("fetch_rsp_vld", s_iv, 1); chk("fetch_data", s_id, 32'hDEADBEEF);
    chk("fetch_err", s_ie, 0);

    // Store then load same address back to back.
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h10; d_req_wdata = 32'h12345678;
    cyc(); chk("st_ready", s_dr, 1); chk("st_we", s_we, 1);
    d_req_we = 0; d_req_wdata = 0;
    cyc(); chk("st_rsp_vld", s_dv, 1); chk("st_rsp_data", s_dd, 0);
    d_req_valid = 0;
    cyc(); chk("ld_rsp_vld", s_dv, 1); chk("ld_rsp_data", s_dd, 32'h12345678);

    // Continuous conflict: starvation guard hands every fifth slot to fetch.
`ifdef MEM_ARB_PERF_EN
    pc0 = perf_conflicts;
`endif
    pat = "DDDDIDDDDI";
    i_req_valid = 1; i_req_addr = 32'h4; d_req_valid = 1; d_req_we = 0; d_req_addr = 32'hC;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("conflict_i_grant", s_ir, pat[k] == "I");
      chk("conflict_d_grant", s_dr, pat[k] == "D");
    end
    i_req_valid = 0; d_req_valid = 0;
    cyc();
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflicts", perf_conflicts - pc0, 10);
`endif

    // Illegal stores: misaligned, then out of range (would alias word 0 if decoded).
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h13; d_req_wdata = 32'hBAD0BAD0;
    cyc(); chk("mis_ready", s_dr, 1); chk("mis_we", s_we, 0);
    d_req_addr = 32'h100;
    cyc(); chk("mis_rsp_err", s_de, 1); chk("mis_rsp_vld", s_dv, 1); chk("oor_we", s_we, 0);
    d_req_we = 0; d_req_addr = 32'h0;
    cyc(); chk("oor_rsp_err", s_de, 1);
    d_req_valid = 0;
    cyc(); chk("word0_intact", s_dd, 32'h1000_0000); chk("word0_err", s_de, 0);

    // Reset lands between a fetch grant and its response edge.
    i_req_valid = 1; i_req_addr = 32'h8;
    @(negedge clk); chk("rst_mid_grant", i_req_ready, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1 i_req_valid = 0;
    @(posedge clk); #1 rst = 1'b0;
    cyc(); chk("rst_mid_no_rsp", s_iv, 0);
    cyc(); chk("rst_mid_no_rsp2", s_iv, 0);

    // Starvation count is cleared by reset.
    i_req_valid = 1; i_req_addr = 32'h4; d_req_valid = 1; d_req_addr = 32'h8;
    repeat (3) cyc();
    reset_mid();
    i_req_valid = 1; d_req_valid = 1;
    pat = "DDDDI";
    for (int k = 0; k < 5; k++) begin
      cyc(); chk("post_rst_grant", s_ir, pat[k] == "I");
    end
    i_req_valid = 0; d_req_valid = 0;
    cyc();

    // Alternating single requests: one response per cycle on the right port.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        i_req_valid = 1; i_req_addr = 32'(k * 4); d_req_valid = 0;
      end else begin
        i_req_valid = 0; d_req_valid = 1; d_req_we = 0; d_req_addr = 32'(k * 4);
      end
      cyc();
      if (k > 0) begin
        chk("alt_i_pulse", s_iv, k % 2 == 1);
        chk("alt_d_pulse", s_dv, k % 2 == 0);
      end
    end
    i_req_valid = 0; d_req_valid = 0;
    cyc(); chk("alt_last_d", s_dv, 1); chk("alt_last_i", s_iv, 0);

    // Random traffic honouring hold-until-ready, with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      if (!i_req_valid || s_ir) begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_req_addr  = rnd_addr();
      end
      if (!d_req_valid || s_dr) begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_addr  = rnd_addr();
        d_req_wdata = $urandom();
      end
      cyc();
      if ($urandom_range(0, 399) == 0) reset_mid();
    end
    i_req_valid = 0; d_req_valid = 0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port word memory (combinational read, synchronous word-aligned write) between the RV32I instruction-fetch port and the load/store data port. Accepts at most one request per cycle, drives the memory address/write lines, and returns registered responses one cycle later. Data port has fixed priority; a starvation counter guarantees fetch progress. Sits between the core front-end/LSU and the memory instance.

Parameters:
WORDS, 64, memory depth in 32-bit words; word index addr[31:2] >= WORDS is out of range
STARVE_LIMIT, 4, consecutive fetch losses after which fetch wins the next conflict (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
i_req_valid  in  1  fetch request
i_req_addr  in  32  fetch byte address
i_req_ready  out  1  fetch request accepted this cycle (combinational)
i_rsp_valid  out  1  fetch response, one-cycle pulse
i_rsp_data  out  32  fetched word
i_rsp_err  out  1  fetch misaligned/out of range
d_req_valid  in  1  data request
d_req_we  in  1  1=store, 0=load
d_req_addr  in  32  data byte address
d_req_wdata  in  32  store data
d_req_ready  out  1  data request accepted this cycle (combinational)
d_rsp_valid  out  1  data response, one-cycle pulse
d_rsp_data  out  32  load word (0 for stores)
d_rsp_err  out  1  data misaligned/out of range
mem_address  out  32  to memory address
mem_write_data  out  32  to memory write_data
mem_write_enable  out  1  to memory write_enable
mem_read_data  in  32  from memory read_data

Behaviour:
- Reset (async, rst=1): all rsp_valid/rsp_err = 0, rsp_data = 0, starve_cnt = 0; ready outputs and mem_write_enable forced 0 while rst high.
- Grant (combinational, per cycle): only d valid -> D; only i valid -> I; both -> D unless starve_cnt >= STARVE_LIMIT, then I. Neither -> no grant, mem_address = 0, mem_write_enable = 0.
- Winner's ready = 1; loser's ready = 0; requester must hold valid/addr/wdata stable until ready.
- mem_address = winner's address; mem_write_data = d_req_wdata; mem_write_enable = 1 only for a granted, legal store.
- Legal = addr[1:0]==0 and addr[31:2] < WORDS. Illegal request: still granted and consumed, no write, rsp_err = 1, rsp_data = 0.
- Response: cycle after grant, winner's rsp_valid = 1 for exactly one cycle; rsp_data = mem_read_data sampled at grant edge (loads/fetches), 0 for stores; other port's rsp_valid = 0. No response backpressure.
- Throughput: one grant per cycle, back-to-back allowed; latency request-accept to response = 1 cycle.
- starve_cnt: +1 (saturating at STARVE_LIMIT) when i_req_valid and D granted; cleared when I granted or i_req_valid = 0.
- Store then load same address on consecutive cycles: load returns stored value (write lands at grant edge).
- Reset mid-transaction: pending response dropped, no rsp_valid after rst deasserts until a new grant.

Optional Feature:
MEM_ARB_PERF_EN: when defined, adds outputs perf_i_grants, perf_d_grants, perf_conflicts (32 bits each, reset 0, wrap on overflow), incremented on I grant, D grant, and cycles with both valid respectively. When undefined, ports and counters are absent; arbitration unchanged.

Test Plan:
- Mem preloaded word 2 = 0xDEADBEEF; i_req addr 0x8 alone -> i_req_ready same cycle, next cycle i_rsp_valid=1, i_rsp_data=0xDEADBEEF, err=0.
- d store addr 0x10 wdata 0x12345678, next cycle d load 0x10 -> store rsp data 0, load rsp data 0x12345678.
- Both valid continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; perf_conflicts=10 with MEM_ARB_PERF_EN.
- d store addr 0x13 -> mem_write_enable stays 0, d_rsp_err=1; store addr 0x100 (WORDS=64) -> d_rsp_err=1, memory unchanged.
- Fetch granted, rst asserted before next edge -> i_rsp_valid stays 0 after release; starve_cnt=0.
- Alternating single requests every cycle -> one response per cycle, no bubbles, correct port pulsed.
